// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, instruction fetch over a ready handshake,
// and next-PC selection for the extended single-cycle MIPS core.
//
// Handshake: imem_req is high in FETCH and WAIT; a fetch completes on the
// first WAIT cycle in which imem_ready is high, when imem_data is captured
// into IR. In EXEC the core is stalled while MIO_ready is low; Branch and
// rs_data are consumed only on the EXEC cycle in which MIO_ready is high.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic [1:0]  Branch,
    input  logic        Jal,
    input  logic [31:0] rs_data,
    input  logic        MIO_ready,
    output logic [31:0] PC_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_out,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic        inst_valid,
    output logic        misalign_err,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        EXEC  = 2'd3
    } state_t;

    localparam int              CW       = $clog2(FETCH_TIMEOUT) + 1;
    localparam logic [CW-1:0]   TMO_LAST = CW'(FETCH_TIMEOUT - 1);

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   ir;
    logic [CW-1:0] tmo_cnt;
    logic [31:0]   next_pc;
    logic          jr_misaligned;

    // Jal only steers the register-file link write; the PC path never needs it.
    logic unused_jal;
    assign unused_jal = Jal;

    assign PC_out    = pc;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign inst_out  = ir;
    assign OPcode    = ir[31:26];
    assign Fun       = ir[5:0];
    assign state_dbg = state;

    // Next-PC mux; a jr to a non-word-aligned target diverts to the exception vector.
    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        case (Branch)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
            2'b10: next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
            default: begin
                if (rs_data[1:0] == 2'b00) begin
                    next_pc = rs_data;
                end else begin
                    next_pc       = EXC_VECTOR;
                    jr_misaligned = 1'b1;
                end
            end
        endcase
    end

    // Fetch/execute sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            ir           <= 32'h0;
            tmo_cnt      <= '0;
            imem_req     <= 1'b0;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    state    <= WAIT;
                    imem_req <= 1'b1;
                    tmo_cnt  <= '0;
                end
                WAIT: begin
                    if (imem_ready) begin
                        // A late ready on the final allowed cycle still completes normally.
                        ir         <= imem_data;
                        tmo_cnt    <= '0;
                        state      <= EXEC;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fetch_err <= 1'b1;
                        pc        <= EXC_VECTOR;
                        ir        <= 32'h0;
                        tmo_cnt   <= '0;
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (MIO_ready) begin
                        pc         <= next_pc;
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        if (jr_misaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed-vector bench for pc_fetch_unit with
// hand-computed next-PC values for sequential, branch, jump and jr flows,
// fetch and data-memory stalls, fetch timeout and asynchronous reset.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [1:0]  Branch;
    logic        Jal;
    logic [31:0] rs_data;
    logic        MIO_ready;
    logic [31:0] PC_out;
    logic [31:0] pc_plus4;
    logic [31:0] inst_out;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic        inst_valid;
    logic        misalign_err;
    logic        fetch_err;
    logic [1:0]  state_dbg;

    int n_cmp;
    int n_err;

    localparam logic [31:0] ST_BOOT  = 32'd0;
    localparam logic [31:0] ST_FETCH = 32'd1;
    localparam logic [31:0] ST_WAIT  = 32'd2;
    localparam logic [31:0] ST_EXEC  = 32'd3;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .Branch       (Branch),
        .Jal          (Jal),
        .rs_data      (rs_data),
        .MIO_ready    (MIO_ready),
        .PC_out       (PC_out),
        .pc_plus4     (pc_plus4),
        .inst_out     (inst_out),
        .OPcode       (OPcode),
        .Fun          (Fun),
        .inst_valid   (inst_valid),
        .misalign_err (misalign_err),
        .fetch_err    (fetch_err),
        .state_dbg    (state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction starting from FETCH: rdly WAIT cycles without
    // imem_ready, then mdly EXEC cycles with MIO_ready low, then commit.
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [1:0] br, input logic [31:0] rs,
                             input int rdly, input int mdly,
                             input logic [31:0] exp_next);
        check("fetch_state", 32'(state_dbg), ST_FETCH);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, pc);
        check("fetch_valid", 32'(inst_valid), 32'd0);
        imem_data  = instr;
        imem_ready = 1'b0;
        tick();
        for (int k = 0; k <= rdly; k++) begin
            check("wait_state", 32'(state_dbg), ST_WAIT);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_pc", PC_out, pc);
            if (k == rdly) imem_ready = 1'b1;
            tick();
        end
        imem_ready = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        Branch     = br;
        rs_data    = rs;
        for (int k = 0; k <= mdly; k++) begin
            check("exec_state", 32'(state_dbg), ST_EXEC);
            check("exec_valid", 32'(inst_valid), 32'd1);
            check("exec_req", 32'(imem_req), 32'd0);
            check("exec_ir", inst_out, instr);
            check("exec_opcode", 32'(OPcode), 32'(instr[31:26]));
            check("exec_fun", 32'(Fun), 32'(instr[5:0]));
            check("exec_pc", PC_out, pc);
            check("exec_plus4", pc_plus4, pc + 32'd4);
            if (k == mdly) MIO_ready = 1'b1;
            tick();
        end
        MIO_ready = 1'b0;
        Branch    = 2'b11;
        rs_data   = 32'h0000_0003;
        check("next_pc", PC_out, exp_next);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, PC_out, 32'h0);
        check({tag, "_ir"}, inst_out, 32'h0);
        check({tag, "_opcode"}, 32'(OPcode), 32'h0);
        check({tag, "_fun"}, 32'(Fun), 32'h0);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
        check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), ST_BOOT);
    endtask

    // Directed stimulus sequence.
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        Branch     = 2'b11;
        Jal        = 1'b0;
        rs_data    = 32'h0000_0003;
        MIO_ready  = 1'b0;
        #1;
        check_reset_values("reset");
        tick();
        tick();
        rst = 1'b0;
        check("boot_state", 32'(state_dbg), ST_BOOT);
        check("boot_req", 32'(imem_req), 32'd0);
        tick();

        // Sequential flow: 0 -> 4 -> 8, three cycles per instruction.
        run_instr(32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0, 0, 0, 32'h0000_0004);
        run_instr(32'h0000_0004, 32'h0000_0020, 2'b00, 32'h0, 0, 0, 32'h0000_0008);

        // Taken branches from 0x40 with imm -2 and +3.
        run_instr(32'h0000_0008, 32'h0000_0008, 2'b11, 32'h0000_0040, 0, 0, 32'h0000_0040);
        run_instr(32'h0000_0040, 32'h1000_FFFE, 2'b01, 32'h0, 0, 0, 32'h0000_003C);
        run_instr(32'h0000_003C, 32'h0000_0008, 2'b11, 32'h0000_0040, 0, 0, 32'h0000_0040);
        run_instr(32'h0000_0040, 32'h1000_0003, 2'b01, 32'h0, 0, 0, 32'h0000_0050);

        // jal from 0xA000_0010 with link value held across a stalled EXEC.
        run_instr(32'h0000_0050, 32'h0000_0008, 2'b11, 32'hA000_0010, 0, 0, 32'hA000_0010);
        Jal = 1'b1;
        run_instr(32'hA000_0010, 32'h0800_0100, 2'b10, 32'h0, 0, 2, 32'hA000_0400);
        Jal = 1'b0;

        // jr aligned, then misaligned.
        run_instr(32'hA000_0400, 32'h0000_0008, 2'b11, 32'h0000_1234, 0, 0, 32'h0000_1234);
        check("misalign_before", 32'(misalign_err), 32'd0);
        run_instr(32'h0000_1234, 32'h0000_0008, 2'b11, 32'h0000_1236, 0, 0, 32'h0000_0180);
        check("misalign_set", 32'(misalign_err), 32'd1);

        // Fetch stall of 5, fetch stall at the last allowed cycle, data stall of 4.
        run_instr(32'h0000_0180, 32'h2442_0001, 2'b00, 32'h0, 5, 0, 32'h0000_0184);
        run_instr(32'h0000_0184, 32'h0000_0025, 2'b00, 32'h0, 15, 0, 32'h0000_0188);
        check("no_fetch_err", 32'(fetch_err), 32'd0);
        run_instr(32'h0000_0188, 32'h8C43_0004, 2'b00, 32'h0, 0, 4, 32'h0000_018C);
        check("misalign_sticky", 32'(misalign_err), 32'd1);

        // Fetch timeout after 16 WAIT cycles with no ready.
        check("tmo_fetch_state", 32'(state_dbg), ST_FETCH);
        imem_ready = 1'b0;
        imem_data  = 32'h1234_5678;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("tmo_wait_state", 32'(state_dbg), ST_WAIT);
            check("tmo_no_err_yet", 32'(fetch_err), 32'd0);
            tick();
        end
        check("tmo_state", 32'(state_dbg), ST_FETCH);
        check("tmo_pc", PC_out, 32'h0000_0180);
        check("tmo_ir", inst_out, 32'h0);
        check("tmo_fetch_err", 32'(fetch_err), 32'd1);
        check("tmo_misalign_kept", 32'(misalign_err), 32'd1);

        // Wrap: jr to 0xFFFF_FFFC then sequential to 0.
        run_instr(32'h0000_0180, 32'h0000_0008, 2'b11, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC);
        run_instr(32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 32'h0, 0, 0, 32'h0000_0000);
        check("flags_still_set", {30'h0, misalign_err, fetch_err}, 32'h3);

        // Asynchronous reset in the middle of EXEC.
        check("mid_fetch_state", 32'(state_dbg), ST_FETCH);
        imem_data  = 32'h1000_0005;
        imem_ready = 1'b1;
        tick();
        tick();
        imem_ready = 1'b0;
        check("mid_exec_state", 32'(state_dbg), ST_EXEC);
        check("mid_exec_ir", inst_out, 32'h1000_0005);
        MIO_ready = 1'b1;
        Branch    = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        tick();
        MIO_ready = 1'b0;
        Branch    = 2'b11;
        check_reset_values("rst_hold");
        rst = 1'b0;
        tick();
        check("post_rst_state", 32'(state_dbg), ST_FETCH);
        check("post_rst_pc", PC_out, 32'h0);
        check("post_rst_req", 32'(imem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
